// File: rtl/cp0_exc_sequencer_if.sv
// Bundle between the CP0 sequencer, the pipeline/exception requesters and the CP0 register file.
// The sequencer takes the slave view; the pipeline-side environment takes the master view.
interface cp0_exc_sequencer_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_req;
  logic        pipe_req;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [2:0]  pipe_sel;
  logic [31:0] pipe_wdata;
  logic        exc_ack;
  logic        eret_ack;
  logic        pipe_ack;
  logic        pipe_rvalid;
  logic [31:0] pipe_rdata;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        cp0_we;
  logic        cp0_re;
  logic [4:0]  cp0_rd;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;

  modport slave (
    input  exc_req, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_req,
           pipe_req, pipe_we, pipe_rd, pipe_sel, pipe_wdata, cp0_rdata,
    output exc_ack, eret_ack, pipe_ack, pipe_rvalid, pipe_rdata, busy,
           redirect, redirect_pc, cp0_we, cp0_re, cp0_rd, cp0_sel, cp0_wdata
  );

  modport master (
    output exc_req, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_req,
           pipe_req, pipe_we, pipe_rd, pipe_sel, pipe_wdata, cp0_rdata,
    input  exc_ack, eret_ack, pipe_ack, pipe_rvalid, pipe_rdata, busy,
           redirect, redirect_pc, cp0_we, cp0_re, cp0_rd, cp0_sel, cp0_wdata
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// Single-port CP0 register file owner: arbitrates MTC0/MFC0 against exception entry and ERET,
// sequences the multi-cycle Status/Cause/EPC/BadVAddr updates and issues the fetch redirect.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          STATUS_EXL = 1
) (
  input  logic              clk,
  input  logic              rst,
  cp0_exc_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, X_RD_ST, X_WR_ST, X_WR_CAUSE, X_WR_EPC, X_WR_BADV, X_REDIR,
    E_RD_EPC, E_RD_ST, E_WR_ST, E_REDIR
  } state_t;

  localparam logic [31:0] EXL_MASK = 32'h1 << STATUS_EXL;

  state_t      state, state_n;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] badv_q;
  logic        old_exl_q;
  logic [31:0] epc_q;
  logic        rvalid_q;
  logic        badv_code;

  assign badv_code       = (code_q == 5'd4) || (code_q == 5'd5);
  assign bus.pipe_rvalid = rvalid_q;
  assign bus.pipe_rdata  = bus.cp0_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rvalid_q  <= 1'b0;
      code_q    <= '0;
      pc_q      <= '0;
      bd_q      <= 1'b0;
      badv_q    <= '0;
      old_exl_q <= 1'b0;
      epc_q     <= '0;
    end else begin
      state    <= state_n;
      rvalid_q <= bus.pipe_ack && !bus.pipe_we;
      if (bus.exc_ack) begin
        code_q <= bus.exc_code;
        pc_q   <= bus.exc_pc;
        bd_q   <= bus.exc_bd;
        badv_q <= bus.exc_badvaddr;
      end
      if (state == X_WR_ST) old_exl_q <= bus.cp0_rdata[STATUS_EXL];
      if (state == E_RD_ST) epc_q <= bus.cp0_rdata;
    end
  end

  // Outputs are forced low while rst is high so a reset mid-sequence can never leak a write.
  always_comb begin
    state_n         = state;
    bus.exc_ack     = 1'b0;
    bus.eret_ack    = 1'b0;
    bus.pipe_ack    = 1'b0;
    bus.busy        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.cp0_we      = 1'b0;
    bus.cp0_re      = 1'b0;
    bus.cp0_rd      = '0;
    bus.cp0_sel     = '0;
    bus.cp0_wdata   = '0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          if (bus.exc_req) begin
            bus.exc_ack = 1'b1;
            state_n     = X_RD_ST;
          end else if (bus.eret_req) begin
            bus.eret_ack = 1'b1;
            state_n      = E_RD_EPC;
          end else if (bus.pipe_req) begin
            bus.pipe_ack  = 1'b1;
            bus.cp0_rd    = bus.pipe_rd;
            bus.cp0_sel   = bus.pipe_sel;
            bus.cp0_wdata = bus.pipe_wdata;
            bus.cp0_we    = bus.pipe_we;
            bus.cp0_re    = !bus.pipe_we;
          end
        end
        X_RD_ST: begin
          bus.cp0_re = 1'b1;
          bus.cp0_rd = 5'd12;
          state_n    = X_WR_ST;
        end
        X_WR_ST: begin
          bus.cp0_we    = 1'b1;
          bus.cp0_rd    = 5'd12;
          bus.cp0_wdata = bus.cp0_rdata | EXL_MASK;
          state_n       = X_WR_CAUSE;
        end
        X_WR_CAUSE: begin
          bus.cp0_we    = 1'b1;
          bus.cp0_rd    = 5'd13;
          bus.cp0_wdata = {(old_exl_q ? 1'b0 : bd_q), 24'b0, code_q, 2'b0};
          // A nested exception keeps the original EPC, so it skips straight past it.
          if (!old_exl_q)     state_n = X_WR_EPC;
          else if (badv_code) state_n = X_WR_BADV;
          else                state_n = X_REDIR;
        end
        X_WR_EPC: begin
          bus.cp0_we    = 1'b1;
          bus.cp0_rd    = 5'd14;
          bus.cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
          state_n       = badv_code ? X_WR_BADV : X_REDIR;
        end
        X_WR_BADV: begin
          bus.cp0_we    = 1'b1;
          bus.cp0_rd    = 5'd8;
          bus.cp0_wdata = badv_q;
          state_n       = X_REDIR;
        end
        X_REDIR: begin
          bus.redirect    = 1'b1;
          bus.redirect_pc = EXC_VECTOR;
          state_n         = IDLE;
        end
        E_RD_EPC: begin
          bus.cp0_re = 1'b1;
          bus.cp0_rd = 5'd14;
          state_n    = E_RD_ST;
        end
        E_RD_ST: begin
          bus.cp0_re = 1'b1;
          bus.cp0_rd = 5'd12;
          state_n    = E_WR_ST;
        end
        E_WR_ST: begin
          bus.cp0_we    = 1'b1;
          bus.cp0_rd    = 5'd12;
          bus.cp0_wdata = bus.cp0_rdata & ~EXL_MASK;
          state_n       = E_REDIR;
        end
        E_REDIR: begin
          bus.redirect    = 1'b1;
          bus.redirect_pc = epc_q;
          state_n         = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Scoreboard bench for cp0_exc_sequencer: expected regfile writes, MFC0 data and redirects are
// queued when requests are issued and matched against DUT activity seen on the falling edge.
module tb_cp0_exc_sequencer;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] pc;
    int          lat;
  } redir_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testCount = 0;
  int   failCount = 0;
  int   cycle = 0;
  int   seqAccept = 0;
  int   lastRdGrant = 0;

  wr_t         wrQ[$];
  logic [31:0] rdQ[$];
  redir_t      redirQ[$];
  int          ackLog[$];
  logic [31:0] shadow [256];

  logic [31:0] mem [256] = '{default: '0};
  logic [7:0]  raddr = 8'h0;

  cp0_exc_sequencer_if bus ();

  cp0_exc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Register file with a registered read address: data appears the cycle after cp0_re.
  always @(posedge clk) begin
    if (bus.cp0_we) mem[{bus.cp0_rd, bus.cp0_sel}] <= bus.cp0_wdata;
    if (bus.cp0_re) raddr <= {bus.cp0_rd, bus.cp0_sel};
  end
  assign bus.cp0_rdata = mem[raddr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t    w;
    redir_t r;
    logic [31:0] d;
    if (bus.pipe_rvalid) begin
      if (rdQ.size() == 0) checkOutput("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        d = rdQ.pop_front();
        checkOutput("mfc0_rdata", bus.pipe_rdata, d);
        checkOutput("rvalid_latency", cycle, lastRdGrant + 1);
      end
    end
    if (bus.pipe_ack && !bus.pipe_we) lastRdGrant = cycle;
    if (bus.cp0_we && bus.cp0_re) checkOutput("we_re_together", 32'd1, 32'd0);
    if (bus.cp0_we) begin
      if (wrQ.size() == 0) checkOutput("unexpected_write", {24'b0, bus.cp0_rd, bus.cp0_sel}, 32'hFFFF_FFFF);
      else begin
        w = wrQ.pop_front();
        checkOutput("wr_addr", {24'b0, bus.cp0_rd, bus.cp0_sel}, {24'b0, w.addr});
        checkOutput("wr_data", bus.cp0_wdata, w.data);
      end
    end
    if (bus.exc_ack) begin seqAccept = cycle; ackLog.push_back(1); end
    if (bus.eret_ack) begin seqAccept = cycle; ackLog.push_back(2); end
    if (bus.pipe_ack) ackLog.push_back(3);
    if (bus.redirect) begin
      if (redirQ.size() == 0) checkOutput("unexpected_redirect", bus.redirect_pc, 32'hFFFF_FFFF);
      else begin
        r = redirQ.pop_front();
        checkOutput("redirect_pc", bus.redirect_pc, r.pc);
        checkOutput("redirect_latency", cycle - seqAccept, r.lat);
      end
    end
  end

  task automatic pushWr(input logic [7:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wrQ.push_back(w);
    shadow[addr] = data;
  endtask

  task automatic pushExc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [31:0] badv);
    redir_t r;
    logic oldExl;
    logic badvCode;
    oldExl   = shadow[8'h60][1];
    badvCode = (code == 5'd4) || (code == 5'd5);
    pushWr(8'h60, shadow[8'h60] | 32'h2);
    pushWr(8'h68, {(oldExl ? 1'b0 : bd), 24'b0, code, 2'b0});
    if (!oldExl) pushWr(8'h70, bd ? pc - 32'd4 : pc);
    if (badvCode) pushWr(8'h40, badv);
    r.pc  = 32'hBFC00380;
    r.lat = 4 + (oldExl ? 0 : 1) + (badvCode ? 1 : 0);
    redirQ.push_back(r);
  endtask

  task automatic pushEret();
    redir_t r;
    r.pc  = shadow[8'h70];
    r.lat = 4;
    pushWr(8'h60, shadow[8'h60] & ~32'h2);
    redirQ.push_back(r);
  endtask

  task automatic applyExc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic [31:0] badv);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.exc_code = code; bus.exc_pc = pc; bus.exc_bd = bd; bus.exc_badvaddr = badv;
    bus.exc_req = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.exc_ack;
    end
    checkOutput("exc_ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    bus.exc_req = 1'b0;
  endtask

  task automatic applyEret();
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.eret_req = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.eret_ack;
    end
    checkOutput("eret_ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    bus.eret_req = 1'b0;
  endtask

  task automatic applyPipe(input logic we, input logic [4:0] rd, input logic [2:0] sel,
                           input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.pipe_we = we; bus.pipe_rd = rd; bus.pipe_sel = sel; bus.pipe_wdata = wdata;
    bus.pipe_req = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.pipe_ack;
    end
    checkOutput("pipe_ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    bus.pipe_req = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] data);
    pushWr({rd, 3'b0}, data);
    applyPipe(1'b1, rd, 3'd0, data);
  endtask

  task automatic waitDrain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy && wrQ.size() == 0 && rdQ.size() == 0 && redirQ.size() == 0;
    end
    checkOutput(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"},
                {23'b0, bus.exc_ack, bus.eret_ack, bus.pipe_ack, bus.pipe_rvalid, bus.busy,
                 bus.redirect, bus.cp0_we, bus.cp0_re, 1'b0}, 32'd0);
    checkOutput({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    bus.exc_req = 1'b0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_bd = 1'b0;
    bus.exc_badvaddr = '0; bus.eret_req = 1'b0; bus.pipe_req = 1'b0; bus.pipe_we = 1'b0;
    bus.pipe_rd = '0; bus.pipe_sel = '0; bus.pipe_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // MTC0 then MFC0 of Status
    mtc0(5'd12, 32'h0000FF01);
    rdQ.push_back(shadow[8'h60]);
    applyPipe(1'b0, 5'd12, 3'd0, 32'h0);
    waitDrain("drain_t1");

    // Plain exception from EXL=0
    mtc0(5'd12, 32'h0);
    pushExc(5'd8, 32'h80001000, 1'b0, 32'h0);
    applyExc(5'd8, 32'h80001000, 1'b0, 32'h0);
    waitDrain("drain_t2");
    checkOutput("t2_status", mem[8'h60], 32'h2);
    checkOutput("t2_cause", mem[8'h68], 32'h20);
    checkOutput("t2_epc", mem[8'h70], 32'h80001000);

    // Address error in a delay slot writes BadVAddr
    mtc0(5'd12, 32'h0);
    pushExc(5'd4, 32'h80000008, 1'b1, 32'h13);
    applyExc(5'd4, 32'h80000008, 1'b1, 32'h13);
    waitDrain("drain_t3");
    checkOutput("t3_cause", mem[8'h68], 32'h80000010);
    checkOutput("t3_epc", mem[8'h70], 32'h80000004);
    checkOutput("t3_badv", mem[8'h40], 32'h13);

    // Nested exception with EXL already set leaves EPC alone
    pushExc(5'd10, 32'h80000100, 1'b1, 32'h0);
    applyExc(5'd10, 32'h80000100, 1'b1, 32'h0);
    waitDrain("drain_t4");
    checkOutput("t4_cause", mem[8'h68], 32'h28);
    checkOutput("t4_epc", mem[8'h70], 32'h80000004);

    // ERET
    mtc0(5'd14, 32'h80002000);
    mtc0(5'd12, 32'h3);
    pushEret();
    applyEret();
    waitDrain("drain_t5");
    checkOutput("t5_status", mem[8'h60], 32'h1);

    // All three requesters at once; exception at PC 0 in a delay slot wraps EPC
    ackLog.delete();
    pushExc(5'd0, 32'h0, 1'b1, 32'h0);
    pushEret();
    pushWr(8'h48, 32'h12345678);
    fork
      applyExc(5'd0, 32'h0, 1'b1, 32'h0);
      applyEret();
      applyPipe(1'b1, 5'd9, 3'd0, 32'h12345678);
    join
    waitDrain("drain_t6");
    checkOutput("t6_ack_count", ackLog.size(), 32'd3);
    if (ackLog.size() == 3) begin
      checkOutput("t6_ack_first", ackLog[0], 32'd1);
      checkOutput("t6_ack_second", ackLog[1], 32'd2);
      checkOutput("t6_ack_third", ackLog[2], 32'd3);
    end
    checkOutput("t6_epc_wrap", mem[8'h70], 32'hFFFFFFFC);

    // Reset while in X_WR_CAUSE: only the Status write may have happened
    pushWr(8'h60, shadow[8'h60] | 32'h2);
    @(posedge clk); #1;
    bus.exc_code = 5'd12; bus.exc_pc = 32'h80003000; bus.exc_bd = 1'b0;
    bus.exc_req = 1'b1;
    @(negedge clk);
    checkOutput("t7_exc_ack", {31'b0, bus.exc_ack}, 32'd1);
    @(posedge clk); #1;
    bus.exc_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("t7_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("t7_post_reset", {30'b0, bus.busy, bus.cp0_we}, 32'd0);
    end
    checkOutput("t7_wr_left", wrQ.size(), 32'd0);
    checkOutput("t7_redir_left", redirQ.size(), 32'd0);
    checkOutput("t7_cause_kept", mem[8'h68], 32'h80000000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
